// File: rtl/uart_tx.sv
// UART transmitter: serialises one word per frame as start bit, LSB-first
// payload, optional parity bit and one or two stop bits. Bit timing comes
// entirely from the external baud_tick strobe.
module uart_tx #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int CNT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

   // Reject parameter combinations the datapath is not sized for.
   generate
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
         $error("uart_tx: DATA_BITS must be in 5..9");
      end
      if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
         $error("uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
         $error("uart_tx: STOP_BITS must be 1 or 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   state_t               state_reg,    state_next;
   logic [DATA_BITS-1:0] shift_reg,    shift_next;
   logic [CNT_W-1:0]     bit_cnt_reg,  bit_cnt_next;
   logic                 stop_cnt_reg, stop_cnt_next;
   logic                 parity_reg,   parity_next;
   logic                 tx_reg,       tx_next;
   logic                 done_reg,     done_next;

   // State and datapath registers; reset drops any frame in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         shift_reg    <= '0;
         bit_cnt_reg  <= '0;
         stop_cnt_reg <= 1'b0;
         parity_reg   <= 1'b0;
         tx_reg       <= 1'b1;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         shift_reg    <= shift_next;
         bit_cnt_reg  <= bit_cnt_next;
         stop_cnt_reg <= stop_cnt_next;
         parity_reg   <= parity_next;
         tx_reg       <= tx_next;
         done_reg     <= done_next;
      end
   end

   // Next-state logic: accept in IDLE, otherwise advance only on baud_tick.
   always_comb begin
      state_next    = state_reg;
      shift_next    = shift_reg;
      bit_cnt_next  = bit_cnt_reg;
      stop_cnt_next = stop_cnt_reg;
      parity_next   = parity_reg;
      tx_next       = tx_reg;
      done_next     = 1'b0;

      case (state_reg)
         IDLE: begin
            // A tick in the accept cycle is deliberately ignored: SYNC
            // realigns the start bit to the next full tick period.
            if (s_valid) begin
               shift_next  = s_data;
               parity_next = (PARITY == 1) ? ~(^s_data) : ^s_data;
               state_next  = SYNC;
            end
         end
         SYNC: begin
            if (baud_tick) begin
               tx_next    = 1'b0;
               state_next = START;
            end
         end
         START: begin
            if (baud_tick) begin
               tx_next      = shift_reg[0];
               shift_next   = shift_reg >> 1;
               bit_cnt_next = '0;
               state_next   = DATA;
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (bit_cnt_reg == LAST_BIT) begin
                  if (PARITY != 0) begin
                     tx_next    = parity_reg;
                     state_next = PAR;
                  end else begin
                     tx_next       = 1'b1;
                     stop_cnt_next = 1'b0;
                     state_next    = STOP;
                  end
               end else begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
                  tx_next      = shift_reg[0];
                  shift_next   = shift_reg >> 1;
               end
            end
         end
         PAR: begin
            if (baud_tick) begin
               tx_next       = 1'b1;
               stop_cnt_next = 1'b0;
               state_next    = STOP;
            end
         end
         STOP: begin
            if (baud_tick) begin
               if (stop_cnt_reg == LAST_STOP) begin
                  tx_next    = 1'b1;
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  stop_cnt_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

   assign s_ready = (state_reg == IDLE);
   assign busy    = (state_reg != IDLE);
   assign tx      = tx_reg;
   assign done    = done_reg;

endmodule
